// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch / data) arbiter in front of a
// single memory port, one transaction in flight, fixed read latency MEM_LAT.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on ties;
// the default build gives the data requester fixed priority.
module mem_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic              r_owner;      // 1 = data requester, 0 = fetch
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;

    logic              w_any;
    logic              w_pick_dm;
    logic              w_first;
    logic              w_done;

    assign w_any   = if_req | dm_req;
    // The counter is loaded with MEM_LAT-1, so that value marks the first ACCESS cycle.
    assign w_first = (r_state == ACCESS) && (r_cnt == LAT_M1);
    assign w_done  = (r_state == ACCESS) && (r_cnt == '0);

`ifdef MEM_ARB_RR_EN
    logic r_last_dm;

    // On a tie, the requester not served last wins
    always_comb begin
        w_pick_dm = dm_req && (!if_req || !r_last_dm);
    end

    // Last-served pointer, updated at every grant; resets to fetch
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_dm <= 1'b0;
        end else if (r_state == IDLE && w_any) begin
            r_last_dm <= w_pick_dm;
        end
    end
`else
    // Fixed priority: data requester always wins
    always_comb begin
        w_pick_dm = dm_req;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = ACCESS;
            ACCESS:  if (r_cnt == '0) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Transaction latch, latency counter and per-requester read data
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_owner    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_owner <= w_pick_dm;
                r_addr  <= w_pick_dm ? dm_addr : if_addr;
                r_wdata <= w_pick_dm ? dm_wdata : '0;
                r_we    <= w_pick_dm & dm_we;
                r_cnt   <= LAT_M1;
            end else if (r_state == ACCESS && r_cnt != '0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_done && !r_we) begin
                if (r_owner) begin
                    r_dm_rdata <= mem_rdata;
                end else begin
                    r_if_rdata <= mem_rdata;
                end
            end
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        if_gnt    = 1'b0;
        dm_gnt    = 1'b0;
        if_rvalid = 1'b0;
        dm_rvalid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr    = 1'b0;
        busy      = (r_state != IDLE);
        if_rdata  = r_if_rdata;
        dm_rdata  = r_dm_rdata;
        if (w_first) begin
            if_gnt = !r_owner;
            dm_gnt = r_owner;
            mem_wr = r_we;
        end
        if (r_state == ACCESS) begin
            mem_addr  = r_addr;
            mem_wdata = r_wdata;
        end
        if (r_state == RESP) begin
            if_rvalid = !r_owner;
            dm_rvalid = r_owner;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: instance u_dut uses MEM_LAT=2,
// instance u_dut1 uses MEM_LAT=1. Cycle 0 of each scenario is the cycle in
// which the request is first driven; outputs are sampled 1 time unit after
// the rising edge that starts a cycle.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic        if_req, dm_req, dm_we;
    logic [63:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_wr, busy;
    logic [63:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    logic        b_if_req, b_dm_req, b_dm_we;
    logic [63:0] b_if_addr, b_dm_addr, b_dm_wdata, b_mem_rdata;
    logic        b_if_gnt, b_if_rvalid, b_dm_gnt, b_dm_rvalid, b_mem_wr, b_busy;
    logic [63:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(2)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wr(b_mem_wr),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        next_cyc();
        next_cyc();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        if_req = 0; dm_req = 0; dm_we = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        b_if_req = 0; b_dm_req = 0; b_dm_we = 0;
        b_if_addr = '0; b_dm_addr = '0; b_dm_wdata = '0; b_mem_rdata = '0;
        #1;
        do_reset();

        // Reset state
        chk("rst_busy",    64'(busy), 64'd0);
        chk("rst_gnt",     64'({if_gnt, dm_gnt}), 64'd0);
        chk("rst_rvalid",  64'({if_rvalid, dm_rvalid}), 64'd0);
        chk("rst_rdata",   if_rdata | dm_rdata, 64'd0);
        chk("rst_mem",     mem_addr | mem_wdata | 64'(mem_wr), 64'd0);
        next_cyc();

        // Single fetch, MEM_LAT=2
        if_req = 1; if_addr = 64'h40;
        chk("f0_gnt", 64'(if_gnt), 64'd0);
        next_cyc();                                   // cycle 1
        chk("f1_gnt",   64'(if_gnt), 64'd1);
        chk("f1_addr",  mem_addr, 64'h40);
        chk("f1_wr",    64'(mem_wr), 64'd0);
        chk("f1_busy",  64'(busy), 64'd1);
        if_req = 0; mem_rdata = 64'h1111;
        next_cyc();                                   // cycle 2
        chk("f2_gnt",   64'(if_gnt), 64'd0);
        chk("f2_addr",  mem_addr, 64'h40);
        mem_rdata = 64'hCAFE_F00D_1234_5678;
        next_cyc();                                   // cycle 3
        chk("f3_rvalid", 64'(if_rvalid), 64'd1);
        chk("f3_rdata",  if_rdata, 64'hCAFE_F00D_1234_5678);
        chk("f3_addr",   mem_addr, 64'd0);
        chk("f3_dmrv",   64'(dm_rvalid), 64'd0);
        next_cyc();                                   // cycle 4
        chk("f4_rvalid", 64'(if_rvalid), 64'd0);
        chk("f4_busy",   64'(busy), 64'd0);

        // Store
        dm_req = 1; dm_we = 1; dm_addr = 64'hFE; dm_wdata = 64'hDEAD_BEEF;
        mem_rdata = 64'h5555;
        next_cyc();                                   // cycle 1
        chk("s1_gnt",   64'(dm_gnt), 64'd1);
        chk("s1_wr",    64'(mem_wr), 64'd1);
        chk("s1_addr",  mem_addr, 64'hFE);
        chk("s1_wdata", mem_wdata, 64'hDEAD_BEEF);
        dm_req = 0; dm_we = 0;
        next_cyc();                                   // cycle 2
        chk("s2_wr",    64'(mem_wr), 64'd0);
        chk("s2_wdata", mem_wdata, 64'hDEAD_BEEF);
        next_cyc();                                   // cycle 3
        chk("s3_rvalid", 64'(dm_rvalid), 64'd1);
        chk("s3_dmrdata", dm_rdata, 64'd0);
        chk("s3_ifrdata", if_rdata, 64'hCAFE_F00D_1234_5678);
        chk("s3_wr",     64'(mem_wr), 64'd0);
        next_cyc();                                   // cycle 4 (idle)

        // Tie after reset: data wins in either arbitration mode
        do_reset();
        next_cyc();
        if_req = 1; if_addr = 64'h20;
        dm_req = 1; dm_addr = 64'h10; dm_we = 0;
        next_cyc();                                   // cycle 1
        chk("p1_dmgnt", 64'(dm_gnt), 64'd1);
        chk("p1_ifgnt", 64'(if_gnt), 64'd0);
        chk("p1_addr",  mem_addr, 64'h10);
        dm_req = 0; mem_rdata = 64'hAAAA;
        next_cyc();                                   // cycle 2
        next_cyc();                                   // cycle 3
        chk("p3_dmrv",  64'(dm_rvalid), 64'd1);
        chk("p3_dmrd",  dm_rdata, 64'hAAAA);
        mem_rdata = 64'hBBBB;
        next_cyc();                                   // cycle 4
        chk("p4_ifgnt", 64'(if_gnt), 64'd0);
        next_cyc();                                   // cycle 5
        chk("p5_ifgnt", 64'(if_gnt), 64'd1);
        chk("p5_addr",  mem_addr, 64'h20);
        if_req = 0;
        next_cyc();                                   // cycle 6
        chk("p6_ifrv",  64'(if_rvalid), 64'd0);
        next_cyc();                                   // cycle 7
        chk("p7_ifrv",  64'(if_rvalid), 64'd1);
        chk("p7_ifrd",  if_rdata, 64'hBBBB);
        chk("p7_dmrd",  dm_rdata, 64'hAAAA);
        next_cyc();

        // Both requests held for four transactions
        do_reset();
        next_cyc();
        if_req = 1; dm_req = 1; dm_we = 0;
        for (int k = 0; k < 4; k++) begin
            logic exp_dm;
`ifdef MEM_ARB_RR_EN
            exp_dm = (k % 2 == 0);
`else
            exp_dm = 1'b1;
`endif
            next_cyc();                               // grant cycle
            chk($sformatf("h%0d_dmgnt", k), 64'(dm_gnt), 64'(exp_dm));
            chk($sformatf("h%0d_ifgnt", k), 64'(if_gnt), 64'(!exp_dm));
            next_cyc();
            next_cyc();
            next_cyc();                               // back in IDLE
        end
        if_req = 0; dm_req = 0;
        next_cyc();
        next_cyc();

        // Reset in the middle of a read
        if_req = 1; if_addr = 64'h80;
        next_cyc();                                   // cycle 1
        chk("r1_gnt", 64'(if_gnt), 64'd1);
        if_req = 0;
        next_cyc();                                   // cycle 2
        chk("r2_addr", mem_addr, 64'h80);
        rst = 1'b0;
        next_cyc();                                   // cycle 3
        chk("r3_busy",  64'(busy), 64'd0);
        chk("r3_addr",  mem_addr, 64'd0);
        chk("r3_out",   64'({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_wr}), 64'd0);
        chk("r3_rdata", if_rdata | dm_rdata | mem_wdata, 64'd0);
        rst = 1'b1;
        for (int c = 4; c < 8; c++) begin
            next_cyc();
            chk($sformatf("r%0d_rv", c), 64'({if_rvalid, dm_rvalid}), 64'd0);
        end

        // MEM_LAT=1, data read held continuously
        b_dm_req = 1; b_dm_we = 0; b_dm_addr = 64'h300; b_mem_rdata = 64'h77;
        chk("l0_gnt", 64'(b_dm_gnt), 64'd0);
        for (int c = 1; c <= 8; c++) begin
            next_cyc();
            chk($sformatf("l%0d_gnt", c), 64'(b_dm_gnt), 64'(c == 1 || c == 4 || c == 7));
            chk($sformatf("l%0d_rv", c),  64'(b_dm_rvalid), 64'(c == 2 || c == 5 || c == 8));
            if (c == 2) chk("l2_rdata", b_dm_rdata, 64'h77);
        end
        b_dm_req = 0;
        next_cyc();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
